hex_display_ctrl: RTL
=====================

Name: hex_display_ctrl

Overview:
Front end for the board's eight 7-segment digits. Captures a 32-bit value on a start pulse and presents it as eight 4-bit digits, one per downstream hexdriver instance. Two display modes: raw hex (1 cycle), or unsigned decimal via a sequential double-dabble converter (32 cycles). Also produces a leading-zero blank mask and an overflow flag for the top level.

Parameters:
BLANK_EN, 1, 1 = compute leading-zero blank mask; 0 = blank forced to 8'h00

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
value  input  32  unsigned value to display, sampled when start accepted
mode  input  1  0 = hex, 1 = decimal; sampled when start accepted
start  input  1  request; accepted only in IDLE
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse; digits/blank/ovf just updated
digits  output  32  digit i on [4i+3:4i], digit 0 least significant; feeds hexdriver i
blank  output  8  bit i = 1 -> top level should blank digit i
ovf  output  1  decimal value exceeded 99_999_999

Behaviour:
- Reset (async, immediate): state IDLE, busy 0, done 0, digits 32'h0, ovf 0, blank 8'hFE (8'h00 if BLANK_EN=0); internal shift/count regs cleared. Reset mid-conversion aborts it; no done pulse.
- States: IDLE, CONV, DONE. busy = (state != IDLE); done = (state == DONE).
- IDLE, start=1 at edge k: latch value and mode.
  - mode=0: at edge k digits <= value, ovf <= 0, blank updated; go DONE. done high for the cycle after edge k (latency 1).
  - mode=1: load bin <= value, bcd(40 bits, 10 digits) <= 0, count <= 0; go CONV.
- CONV: each edge performs one iteration: every BCD digit >= 5 gets +3, then {bcd,bin} shifted left 1. count increments. On the 32nd iteration (edge k+32) result registered to outputs, go DONE. done high for the cycle after edge k+32.
  - Result: if bcd[39:32] != 0, then ovf <= 1 and digits <= 32'hFFFFFFFF; else ovf <= 0 and digits <= bcd[31:0].
- DONE -> IDLE unconditionally next edge. start can be accepted again the cycle after done.
- start while busy (CONV or DONE) is ignored; the in-flight operation is unaffected.
- digits/blank/ovf hold their previous values throughout CONV (no flicker); they change only on the edge entering DONE.
- blank (BLANK_EN=1): bit 0 always 0. Bit i (i>=1) = 1 iff digits i..7 are all zero. Computed from the new digits and registered together with them. With ovf=1, blank = 8'h00.
- mode/value changes after acceptance are ignored.

Test Plan:
- rst pulse at arbitrary time -> outputs immediately digits=0, blank=8'hFE, ovf=0, busy=0, done=0.
- mode=0, value=32'h1234ABCD, start -> done pulses in the next cycle, digits=32'h1234ABCD, blank=8'h00, ovf=0; busy high for exactly 1 cycle.
- mode=1, value=32'd12345678 -> busy high 33 cycles, done exactly 32 cycles after the start edge, digits=32'h12345678, blank=8'h00, ovf=0. Repeat with 42 -> digits=32'h00000042, blank=8'hFC. Repeat with 0 -> digits=0, blank=8'hFE.
- mode=1, value=99_999_999 -> digits=32'h99999999, ovf=0. Then 100_000_000 -> digits=32'hFFFFFFFF, ovf=1, blank=8'h00. Then 32'hFFFFFFFF -> ovf=1.
- During decimal conversion of 42 (previous display 32'h1234ABCD), pulse start with mode=0, value=7 -> ignored; digits stay 32'h1234ABCD until the done pulse, then become 32'h00000042.
- Assert rst at iteration 10 of a decimal conversion -> immediate reset values, no done pulse. Next start (hex 32'h5) completes normally with digits=32'h5, blank=8'hFE.

Source files
------------

// File: rtl/hex_display_ctrl.sv
// Eight-digit display front end: captures a 32-bit value and presents it
// either as raw hex nibbles or as unsigned decimal (sequential double dabble),
// together with a leading-zero blank mask and a decimal overflow flag.
module hex_display_ctrl #(
    parameter bit BLANK_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] value,
    input  logic        mode,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [31:0] digits,
    output logic [7:0]  blank,
    output logic        ovf
);

    localparam int unsigned DW = 32;   // binary input width
    localparam int unsigned BW = 40;   // BCD accumulator width (10 digits)
    localparam int unsigned ND = 8;    // displayed digits
    localparam int unsigned NB = 10;   // BCD accumulator digits
    localparam int unsigned CW = 5;    // iteration counter width
    localparam logic [CW-1:0] LAST_ITER = CW'(DW - 1);
    localparam logic [7:0] BLANK_RST = BLANK_EN ? 8'hFE : 8'h00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [DW-1:0]   bin, bin_n;
    logic [BW-1:0]   bcd, bcd_n;
    logic [CW-1:0]   count, count_n;
    logic [31:0]     digits_n;
    logic [7:0]      blank_n;
    logic            ovf_n;
    logic [BW+DW-1:0] step_c;

    // Leading-zero mask: bit i set when digits i..7 are all zero; digit 0 always shown
    function automatic logic [7:0] blank_of(input logic [31:0] d, input logic o);
        logic [7:0] b;
        logic       z;
        b = 8'h00;
        z = 1'b1;
        for (int i = ND - 1; i >= 1; i--) begin
            z    = z & (d[4*i +: 4] == 4'h0);
            b[i] = z;
        end
        if (o || !BLANK_EN) begin
            b = 8'h00;
        end
        return b;
    endfunction

    // One double-dabble iteration: add-3 correction on each BCD digit, then shift
    function automatic logic [BW+DW-1:0] dd_step(input logic [BW-1:0] bc,
                                                 input logic [DW-1:0] bn);
        logic [BW-1:0] adj;
        adj = bc;
        for (int i = 0; i < NB; i++) begin
            if (adj[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
            end
        end
        return {adj, bn} << 1;
    endfunction

    assign step_c = dd_step(bcd, bin);
    assign busy   = (state != IDLE);
    assign done   = (state == DONE);

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            bin    <= '0;
            bcd    <= '0;
            count  <= '0;
            digits <= '0;
            blank  <= BLANK_RST;
            ovf    <= 1'b0;
        end else begin
            state  <= state_n;
            bin    <= bin_n;
            bcd    <= bcd_n;
            count  <= count_n;
            digits <= digits_n;
            blank  <= blank_n;
            ovf    <= ovf_n;
        end
    end

    // Next-state and next-output logic; displayed values only move on entry to DONE
    always_comb begin
        state_n  = state;
        bin_n    = bin;
        bcd_n    = bcd;
        count_n  = count;
        digits_n = digits;
        blank_n  = blank;
        ovf_n    = ovf;
        case (state)
            IDLE: begin
                if (start) begin
                    if (mode) begin
                        bin_n   = value;
                        bcd_n   = '0;
                        count_n = '0;
                        state_n = CONV;
                    end else begin
                        digits_n = value;
                        ovf_n    = 1'b0;
                        blank_n  = blank_of(value, 1'b0);
                        state_n  = DONE;
                    end
                end
            end
            CONV: begin
                {bcd_n, bin_n} = step_c;
                count_n        = count + CW'(1);
                if (count == LAST_ITER) begin
                    state_n = DONE;
                    if (step_c[BW+DW-1 -: 8] != 8'h00) begin
                        ovf_n    = 1'b1;
                        digits_n = '1;
                        blank_n  = blank_of('1, 1'b1);
                    end else begin
                        ovf_n    = 1'b0;
                        digits_n = step_c[DW +: 32];
                        blank_n  = blank_of(step_c[DW +: 32], 1'b0);
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
